vga_sprite_compositor: RTL
==========================

Name: vga_sprite_compositor

Overview:
- Next-generation VGA display core for the lastfrog game: a 640x480 timing generator plus an N-slot sprite compositor on a 32x32 grid.
- Each slot is a generic sprite instance: frog, cars, or future logs and turtles.
- Slot positions are written through a double-buffered register port that swaps at frame boundaries.
- The block fetches pixels from an external synchronous sprite ROM, composites over a background, and reports per-frame frog-collision flags.

Parameters:
N_SLOTS, 16, number of sprite slots; slot 0 is the player (frog), and lower index means higher priority
SPR_ID_W, 2, width of sprite-ROM image selector
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch
H_SYNC, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch
V_SYNC, 2, vertical sync width
V_BP, 33, vertical back porch
CELL_LOG2, 5, log2 of grid cell size in pixels

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous active-high reset
wr_en  in  1  slot write strobe
wr_slot  in  $clog2(N_SLOTS)  slot index to write
wr_col  in  5  grid column
wr_row  in  4  grid row
wr_spr  in  SPR_ID_W  sprite image id
wr_vis  in  1  slot visible
rom_spr  out  SPR_ID_W  sprite ROM image select
rom_x  out  5  sprite ROM x offset within cell
rom_y  out  5  sprite ROM y offset within cell
rom_data  in  6  ROM pixel, RRGGBB; value 0 means transparent; returned 1 cycle after the address
pix_x  out  10  stage-1 pixel x, for the background module
pix_y  out  9  stage-1 pixel y
bg_rgb  in  9  background colour {r3,g3,b3}, combinational from pix_x/pix_y
vga_r, vga_g, vga_b  out  3 each  colour output
vga_hs, vga_vs  out  1 each  sync outputs, active low
frame_start  out  1  one-cycle pulse at the table swap
collide  out  N_SLOTS-1  per-slot frog-overlap flags for the previous frame

Behaviour:
Reset:
- Counters go to 0.
- vga_r, vga_g, vga_b = 0; vga_hs = vga_vs = 1.
- frame_start = 0; collide = 0.
- All shadow and active slots: vis = 0, col = row = spr = 0.
- rst mid-frame restarts the timing at (0,0) on the next cycle. The sticky collision accumulator is cleared.

Timing:
- h counts 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800.
- Region order along the line: active (h < H_ACTIVE), then front porch, then sync, then back porch. The vertical counter uses the same order, V_TOTAL = 525.
- v increments when h wraps.
- Sync is low while the counter is inside its sync region.
- active = (h < H_ACTIVE) && (v < V_ACTIVE).

Pipeline (3 stages, fixed latency 3 from counter to pins):
- S0: counters.
- S1: registers pix_x, pix_y and active.
  - Computes the hit vector per slot: vis && pix_x[9:5] == col && pix_y[8:5] == row. Columns or rows beyond the screen never hit.
  - Selects the lowest-index hit and drives rom_spr, rom_x = pix_x[4:0], rom_y = pix_y[4:0], registered.
  - Registers any_hit, bg_rgb and the hit vector.
- S2: rom_data is valid.
  - If !active, output 0.
  - Else if any_hit and rom_data != 0, output {rom_data[5:4],0}, {rom_data[3:2],0}, {rom_data[1:0],0}.
  - Else output bg_rgb.
- Only the top-priority slot is fetched. A transparent pixel in it falls through to background, not to lower slots.
- hs and vs are delayed through the same 3 stages so colour and sync stay aligned.

Slot table:
- wr_en writes the shadow entry wr_slot. A wr_slot >= N_SLOTS is ignored.
- At S0 position (h=0, v=V_ACTIVE), the shadow is copied into the active table and frame_start pulses for 1 cycle.
- A write in the swap cycle is included in that swap (write-through to both tables).
- The active table never changes mid-visible-frame, so there is no tearing.

Collision:
- During active pixels at S1, for each k >= 1, sticky[k-1] is set when hit[0] && hit[k]. This is cell-level, with no transparency test.
- At swap: collide <= sticky | (set terms from the same cycle), then sticky is cleared.
- collide holds for the whole next frame.

Decomposition:
- Shared package vga_pkg: timing localparams (H_ACTIVE..V_BP, H_TOTAL, V_TOTAL), CELL_LOG2, the slot record typedef {vis, col, row, spr}, and the RGB333 type with the RRGGBB-to-RGB333 expansion function.
- Sub-module vga_timing_gen: counters, active flag, raw hs/vs. Reusable by other display modes.

Test Plan:
- Reset, then run 800*525 cycles: hs low for exactly 96 cycles per line starting at h=656+3; vs low for 2 lines; frame_start once per frame at v=480.
- All slots written with vis=1, col=31, row=15 (off-screen cells): output equals bg_rgb delayed 3 cycles everywhere; 0 during blanking.
- Slot 0 at (2,3), slot 5 at (2,3), rom_data=6'b110000 for slot 0's id: pixel (64..95, 96..127) shows r=6, g=0, b=0. rom_spr equals slot 0's id and never slot 5's.
- Same setup with rom_data=0 for slot 0: background shows, not slot 5.
- Write slot 3 to (4,4) mid-visible-frame: display unchanged until after the next frame_start; a write in the exact swap cycle appears in the following frame.
- Slot 0 and slot 7 both at (10,8) for one frame, then separated: collide = 16'h0040 for the next frame, then 0 the frame after. Reset mid-frame clears collide immediately.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: definitions shared by the VGA display core.
//   - Default 640x480 timing constants and their line/frame totals.
//   - Sprite grid geometry: cell size (log2), grid column/row widths.
//   - slot_t: one sprite-slot record {vis, col, row, spr}.
//   - rgb333_t: output colour, plus expansion from 6-bit RRGGBB ROM pixels.
package vga_pkg;
  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int CELL_LOG2 = 5;
  localparam int COL_W     = 5;
  localparam int ROW_W     = 4;
  localparam int SPR_ID_W  = 2;

  typedef struct packed {
    logic             vis;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [SPR_ID_W-1:0] spr;
  } slot_t;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [2:0] b;
  } rgb333_t;

  // Two-bit ROM channels land in the upper bits of each 3-bit channel.
  function automatic rgb333_t rrggbb_to_rgb333(input logic [5:0] c);
    rgb333_t o;
    o.r = {c[5:4], 1'b0};
    o.g = {c[3:2], 1'b0};
    o.b = {c[1:0], 1'b0};
    return o;
  endfunction
endpackage

// File: rtl/vga_sprite_compositor_if.sv
// vga_sprite_compositor_if: slot-table write port.
//   wr_en   write strobe
//   wr_slot slot index (out-of-range indices write nothing)
//   wr_col / wr_row  grid cell, wr_spr image id, wr_vis visible flag
// master drives the port, slave (the compositor) receives it.
interface vga_sprite_compositor_if
  import vga_pkg::*;
#(
  parameter int N_SLOTS      = 16,
  parameter int SLOT_SPR_W   = vga_pkg::SPR_ID_W
);
  logic                       wr_en;
  logic [$clog2(N_SLOTS)-1:0] wr_slot;
  logic [COL_W-1:0]           wr_col;
  logic [ROW_W-1:0]           wr_row;
  logic [SLOT_SPR_W-1:0]      wr_spr;
  logic                       wr_vis;

  modport master (output wr_en, wr_slot, wr_col, wr_row, wr_spr, wr_vis);
  modport slave  (input  wr_en, wr_slot, wr_col, wr_row, wr_spr, wr_vis);
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: horizontal/vertical raster counters.
//   clk, rst   pixel clock, synchronous active-high reset
//   h, v       current counter position (stage 0)
//   active     h and v both inside the visible area
//   hs, vs     raw active-low sync, low while the counter is in its sync region
// Region order per axis: active, front porch, sync, back porch.
module vga_timing_gen #(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] h,
  output logic [9:0] v,
  output logic       active,
  output logic       hs,
  output logic       vs
);
  localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST     = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_ACT_END  = 10'(V_ACTIVE);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST     = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  logic [9:0] h_reg;
  logic [9:0] v_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      h_reg <= '0;
      v_reg <= '0;
    end else if (h_reg == H_LAST) begin
      h_reg <= '0;
      v_reg <= (v_reg == V_LAST) ? '0 : v_reg + 10'd1;
    end else begin
      h_reg <= h_reg + 10'd1;
    end
  end

  assign h      = h_reg;
  assign v      = v_reg;
  assign active = (h_reg < H_ACT_END) && (v_reg < V_ACT_END);
  assign hs     = !((h_reg >= H_SYNC_BEG) && (h_reg < H_SYNC_END));
  assign vs     = !((v_reg >= V_SYNC_BEG) && (v_reg < V_SYNC_END));
endmodule

// File: rtl/vga_sprite_compositor.sv
// vga_sprite_compositor: VGA raster plus N-slot sprite compositor on a
// 32x32-pixel grid.
//   clk, rst          pixel clock, synchronous active-high reset
//   wr_if             slot write port into the shadow table
//   rom_spr/x/y       sprite ROM address (registered), rom_data returns next cycle
//   pix_x, pix_y      stage-1 pixel position for the background source
//   bg_rgb            background colour for pix_x/pix_y
//   vga_r/g/b, vga_hs/vs  colour and active-low sync, 3 cycles after the counter
//   frame_start       one-cycle pulse after the shadow->active table swap
//   collide           per-slot (1..N-1) frog overlap flags from the previous frame
// Slot 0 is the frog; a lower slot index wins where sprites overlap, and
// only the winning slot is fetched from the ROM.
module vga_sprite_compositor
  import vga_pkg::*;
#(
  parameter int N_SLOTS  = 16,
  parameter int SPR_ID_W = vga_pkg::SPR_ID_W,
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP
) (
  input  logic                  clk,
  input  logic                  rst,
  vga_sprite_compositor_if.slave wr_if,
  output logic [SPR_ID_W-1:0]   rom_spr,
  output logic [4:0]            rom_x,
  output logic [4:0]            rom_y,
  input  logic [5:0]            rom_data,
  output logic [9:0]            pix_x,
  output logic [8:0]            pix_y,
  input  logic [8:0]            bg_rgb,
  output logic [2:0]            vga_r,
  output logic [2:0]            vga_g,
  output logic [2:0]            vga_b,
  output logic                  vga_hs,
  output logic                  vga_vs,
  output logic                  frame_start,
  output logic [N_SLOTS-2:0]    collide
);
  localparam int SLOT_W = $clog2(N_SLOTS);

  // ---------------- Stage 0: counters ----------------
  logic [9:0] h;
  logic [9:0] v;
  logic       active0;
  logic       hs0;
  logic       vs0;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk    (clk),
    .rst    (rst),
    .h      (h),
    .v      (v),
    .active (active0),
    .hs     (hs0),
    .vs     (vs0)
  );

  // First blanking line, first pixel: the table swaps on this edge.
  logic swap;
  assign swap = (h == 10'd0) && (v == 10'(V_ACTIVE));

  slot_t wr_val;
  assign wr_val = {wr_if.wr_vis, wr_if.wr_col, wr_if.wr_row, wr_if.wr_spr};

  // ---------------- Slot tables and per-slot hit ----------------
  // The cell compare runs on the stage-0 counter so the hit vector and the
  // ROM address are registered together into stage 1. Hits are gated by the
  // visible area, so off-screen cells can never match.
  logic [N_SLOTS-1:0]               hit0;
  logic [N_SLOTS-1:0][SPR_ID_W-1:0] slot_spr;

  for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_slot
    slot_t shadow_reg;
    slot_t active_reg;
    logic  wr_sel;

    assign wr_sel = wr_if.wr_en && (wr_if.wr_slot == SLOT_W'(gi));

    always_ff @(posedge clk) begin
      if (rst) begin
        shadow_reg <= '0;
        active_reg <= '0;
      end else begin
        if (wr_sel) shadow_reg <= wr_val;
        // A write landing on the swap edge goes straight into this frame.
        if (swap) active_reg <= wr_sel ? wr_val : shadow_reg;
      end
    end

    assign hit0[gi] = active0 && active_reg.vis
                   && (h[CELL_LOG2 +: COL_W] == active_reg.col)
                   && (v[CELL_LOG2 +: ROW_W] == active_reg.row);
    assign slot_spr[gi] = active_reg.spr;
  end

  logic [SPR_ID_W-1:0] sel_spr;
  always_comb begin
    sel_spr = '0;
    for (int k = N_SLOTS - 1; k >= 0; k--) begin
      if (hit0[k]) sel_spr = slot_spr[k];
    end
  end

  // ---------------- Stage 1 ----------------
  logic [9:0]          pix_x_reg;
  logic [8:0]          pix_y_reg;
  logic                active1_reg, hs1_reg, vs1_reg;
  logic [N_SLOTS-1:0]  hit1_reg;
  logic [SPR_ID_W-1:0] rom_spr_reg;
  logic [4:0]          rom_x_reg, rom_y_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_x_reg   <= '0;
      pix_y_reg   <= '0;
      active1_reg <= 1'b0;
      hs1_reg     <= 1'b1;
      vs1_reg     <= 1'b1;
      hit1_reg    <= '0;
      rom_spr_reg <= '0;
      rom_x_reg   <= '0;
      rom_y_reg   <= '0;
    end else begin
      pix_x_reg   <= h;
      pix_y_reg   <= v[8:0];
      active1_reg <= active0;
      hs1_reg     <= hs0;
      vs1_reg     <= vs0;
      hit1_reg    <= hit0;
      rom_spr_reg <= sel_spr;
      rom_x_reg   <= h[4:0];
      rom_y_reg   <= v[4:0];
    end
  end

  // Cell-level frog overlap; transparency is deliberately not considered.
  logic [N_SLOTS-2:0] coll_set;
  logic [N_SLOTS-2:0] sticky_reg;
  logic [N_SLOTS-2:0] collide_reg;
  logic               frame_start_reg;
  assign coll_set = hit1_reg[0] ? hit1_reg[N_SLOTS-1:1] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_reg      <= '0;
      collide_reg     <= '0;
      frame_start_reg <= 1'b0;
    end else begin
      frame_start_reg <= swap;
      if (swap) begin
        collide_reg <= sticky_reg | coll_set;
        sticky_reg  <= '0;
      end else begin
        sticky_reg  <= sticky_reg | coll_set;
      end
    end
  end

  // ---------------- Stage 2: ROM data valid ----------------
  logic    active2_reg, any_hit2_reg, hs2_reg, vs2_reg;
  rgb333_t bg2_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      active2_reg  <= 1'b0;
      any_hit2_reg <= 1'b0;
      hs2_reg      <= 1'b1;
      vs2_reg      <= 1'b1;
      bg2_reg      <= '0;
    end else begin
      active2_reg  <= active1_reg;
      any_hit2_reg <= |hit1_reg;
      hs2_reg      <= hs1_reg;
      vs2_reg      <= vs1_reg;
      bg2_reg      <= bg_rgb;
    end
  end

  // A transparent top-priority pixel shows background, never a lower slot.
  rgb333_t rgb_next;
  always_comb begin
    rgb_next = '0;
    if (active2_reg) begin
      if (any_hit2_reg && (rom_data != 6'd0)) rgb_next = rrggbb_to_rgb333(rom_data);
      else                                     rgb_next = bg2_reg;
    end
  end

  rgb333_t rgb_reg;
  logic    hs3_reg, vs3_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_reg <= '0;
      hs3_reg <= 1'b1;
      vs3_reg <= 1'b1;
    end else begin
      rgb_reg <= rgb_next;
      hs3_reg <= hs2_reg;
      vs3_reg <= vs2_reg;
    end
  end

  assign pix_x       = pix_x_reg;
  assign pix_y       = pix_y_reg;
  assign rom_spr     = rom_spr_reg;
  assign rom_x       = rom_x_reg;
  assign rom_y       = rom_y_reg;
  assign vga_r       = rgb_reg.r;
  assign vga_g       = rgb_reg.g;
  assign vga_b       = rgb_reg.b;
  assign vga_hs      = hs3_reg;
  assign vga_vs      = vs3_reg;
  assign frame_start = frame_start_reg;
  assign collide     = collide_reg;
endmodule
